ct_mat_exu_alu_seq_ctrl: RTL and testbench



---
 rtl/ct_mat_exu_alu_seq_ctrl.sv | 134 +++++++++++++
 tb/tb_ct_mat_exu_alu_seq_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ct_mat_exu_alu_seq_ctrl.sv
// Matrix ALU beat sequencer: walks an accepted instruction's sizeM x sizeK tile in
// DP_BYTES-wide micro-ops, then raises a one-cycle commit on the pipe8 completion bus.
module ct_mat_exu_alu_seq_ctrl #(
    parameter int unsigned DP_BYTES = 16,
    parameter int unsigned BW       = $clog2(DP_BYTES) + 1
) (
    input  logic          forever_cpuclk,
    input  logic          cpurst_b,
    input  logic          rtu_yy_xx_flush,
    input  logic          ex1_inst_vld,
    input  logic [6:0]    ex1_iid,
    input  logic [10:0]   ex1_mat_op,
    input  logic [1:0]    ex1_elem_width,
    input  logic [15:0]   x_sizeK,
    input  logic [7:0]    x_sizeM,
    output logic          seq_idle,
    output logic          uop_vld,
    input  logic          uop_rdy,
    output logic [7:0]    uop_row,
    output logic [15:0]   uop_col,
    output logic [BW-1:0] uop_bytes,
    output logic          uop_last,
    output logic [10:0]   uop_op,
    output logic [1:0]    uop_elem_width,
    output logic          mat_alu_cbus_ex1_pipe8_sel,
    output logic [6:0]    mat_alu_cbus_ex1_pipe8_iid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    localparam logic [16:0] STEP_EXT = 17'(DP_BYTES);
    localparam logic [15:0] STEP     = 16'(DP_BYTES);

    seq_state_t  state;
    logic        idle_q;
    logic [6:0]  iid_l;
    logic [10:0] op_l;
    logic [1:0]  ew_l;
    logic [15:0] size_k_l;
    logic [7:0]  size_m_l;
    logic [7:0]  row;
    logic [15:0] col;

    logic        is_run;
    logic        is_done;
    logic [16:0] col_end_ext;
    logic        row_end;
    logic        row_final;
    logic [15:0] remain;
    logic        handshake;
    logic        zero_tile;

    // Beat geometry; the 17-bit end offset keeps sizeK=0xFFFF from wrapping.
    assign is_run      = (state == RUN);
    assign is_done     = (state == DONE);
    assign col_end_ext = {1'b0, col} + STEP_EXT;
    assign row_end     = (col_end_ext >= {1'b0, size_k_l});
    assign row_final   = (row == size_m_l - 8'd1);
    assign remain      = size_k_l - col;
    assign handshake   = uop_vld && uop_rdy;
    assign zero_tile   = (x_sizeM == 8'd0) || (x_sizeK == 16'd0);

    assign seq_idle       = idle_q;
    assign uop_vld        = is_run && !rtu_yy_xx_flush;
    assign uop_row        = is_run ? row : 8'd0;
    assign uop_col        = is_run ? col : 16'd0;
    assign uop_bytes      = !is_run         ? BW'(0) :
                            (remain < STEP) ? BW'(remain) : BW'(DP_BYTES);
    assign uop_last       = is_run && row_end && row_final;
    assign uop_op         = op_l;
    assign uop_elem_width = ew_l;

    assign mat_alu_cbus_ex1_pipe8_sel = is_done && !rtu_yy_xx_flush;
    assign mat_alu_cbus_ex1_pipe8_iid = (state == IDLE) ? 7'd0 : iid_l;

    // Sequencer state, tile walk position and latched instruction fields.
    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            state    <= IDLE;
            idle_q   <= 1'b1;
            iid_l    <= 7'd0;
            op_l     <= 11'd0;
            ew_l     <= 2'd0;
            size_k_l <= 16'd0;
            size_m_l <= 8'd0;
            row      <= 8'd0;
            col      <= 16'd0;
        end else if (rtu_yy_xx_flush) begin
            state  <= IDLE;
            idle_q <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (ex1_inst_vld) begin
                        iid_l    <= ex1_iid;
                        op_l     <= ex1_mat_op;
                        ew_l     <= ex1_elem_width;
                        size_k_l <= x_sizeK;
                        size_m_l <= x_sizeM;
                        row      <= 8'd0;
                        col      <= 16'd0;
                        idle_q   <= 1'b0;
                        state    <= zero_tile ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (handshake) begin
                        if (!row_end) begin
                            col <= col + STEP;
                        end else if (!row_final) begin
                            col <= 16'd0;
                            row <= row + 8'd1;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    idle_q <= 1'b1;
                end
                default: begin
                    state  <= IDLE;
                    idle_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ct_mat_exu_alu_seq_ctrl.sv
// Scoreboard bench for the matrix ALU sequencer: driver pushes expected beats/commits
// from a tile-walk model, a negedge monitor pops and compares them.
module tb_ct_mat_exu_alu_seq_ctrl;

    localparam int DP = 16;
    localparam int BW = $clog2(DP) + 1;

    logic          forever_cpuclk;
    logic          cpurst_b;
    logic          rtu_yy_xx_flush;
    logic          ex1_inst_vld;
    logic [6:0]    ex1_iid;
    logic [10:0]   ex1_mat_op;
    logic [1:0]    ex1_elem_width;
    logic [15:0]   x_sizeK;
    logic [7:0]    x_sizeM;
    logic          seq_idle;
    logic          uop_vld;
    logic          uop_rdy;
    logic [7:0]    uop_row;
    logic [15:0]   uop_col;
    logic [BW-1:0] uop_bytes;
    logic          uop_last;
    logic [10:0]   uop_op;
    logic [1:0]    uop_elem_width;
    logic          mat_alu_cbus_ex1_pipe8_sel;
    logic [6:0]    mat_alu_cbus_ex1_pipe8_iid;

    ct_mat_exu_alu_seq_ctrl #(.DP_BYTES(DP)) dut (
        .forever_cpuclk             (forever_cpuclk),
        .cpurst_b                   (cpurst_b),
        .rtu_yy_xx_flush            (rtu_yy_xx_flush),
        .ex1_inst_vld               (ex1_inst_vld),
        .ex1_iid                    (ex1_iid),
        .ex1_mat_op                 (ex1_mat_op),
        .ex1_elem_width             (ex1_elem_width),
        .x_sizeK                    (x_sizeK),
        .x_sizeM                    (x_sizeM),
        .seq_idle                   (seq_idle),
        .uop_vld                    (uop_vld),
        .uop_rdy                    (uop_rdy),
        .uop_row                    (uop_row),
        .uop_col                    (uop_col),
        .uop_bytes                  (uop_bytes),
        .uop_last                   (uop_last),
        .uop_op                     (uop_op),
        .uop_elem_width             (uop_elem_width),
        .mat_alu_cbus_ex1_pipe8_sel (mat_alu_cbus_ex1_pipe8_sel),
        .mat_alu_cbus_ex1_pipe8_iid (mat_alu_cbus_ex1_pipe8_iid)
    );

    typedef struct {
        logic [7:0]  row;
        logic [15:0] col;
        int          bytes;
        bit          last;
        logic [10:0] op;
        logic [1:0]  ew;
    } beat_t;

    typedef struct {
        logic [6:0] iid;
        int         n;
        int         acc;
        int         exp_cyc;
    } cmt_t;

    beat_t bq[$];
    cmt_t  cq[$];
    beat_t mb;
    cmt_t  mc;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int last_hs = 0;
    int beats_seen = 0;
    int rdy_mode = 0;
    int rdy_idx = 0;
    logic [3:0] rdy_pat = 4'b1001;

    bit          prev_stall = 0;
    bit          chk_idle = 0;
    logic [7:0]  p_row;
    logic [15:0] p_col;
    logic [BW-1:0] p_bytes;
    logic        p_last;

    initial forever_cpuclk = 1'b0;
    always #5 forever_cpuclk = ~forever_cpuclk;

    always @(posedge forever_cpuclk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Ready driver: 0 = always ready, 1 = repeating 1,0,0,1, 2 = random.
    always @(posedge forever_cpuclk) begin
        #1;
        case (rdy_mode)
            0: uop_rdy = 1'b1;
            1: begin
                uop_rdy = rdy_pat[3 - rdy_idx];
                rdy_idx = (rdy_idx + 1) % 4;
            end
            default: uop_rdy = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: pops the scoreboard on every handshake and every commit pulse.
    always @(negedge forever_cpuclk) begin
        if (cpurst_b) begin
            assert (!(ex1_inst_vld && !seq_idle))
            else begin
                n_mis++;
                $display("FAIL protocol: ex1_inst_vld while busy (cycle %0d)", cyc);
            end
        end
        if (!cpurst_b || rtu_yy_xx_flush) begin
            prev_stall = 0;
            chk_idle   = 0;
        end else begin
            if (chk_idle) begin
                chk("idle_after_commit", 32'(seq_idle), 32'd1);
                chk_idle = 0;
            end
            if (prev_stall) begin
                chk("hold_vld",   32'(uop_vld),   32'd1);
                chk("hold_row",   32'(uop_row),   32'(p_row));
                chk("hold_col",   32'(uop_col),   32'(p_col));
                chk("hold_bytes", 32'(uop_bytes), 32'(p_bytes));
                chk("hold_last",  32'(uop_last),  32'(p_last));
            end
            prev_stall = 0;
            if (uop_vld) begin
                chk("busy_while_vld", 32'(seq_idle), 32'd0);
                if (uop_rdy) begin
                    if (bq.size() == 0) begin
                        chk("beat_unexpected", 32'd1, 32'd0);
                    end else begin
                        mb = bq.pop_front();
                        chk("beat_row",   32'(uop_row),        32'(mb.row));
                        chk("beat_col",   32'(uop_col),        32'(mb.col));
                        chk("beat_bytes", 32'(uop_bytes),      32'(mb.bytes));
                        chk("beat_last",  32'(uop_last),       32'(mb.last));
                        chk("beat_op",    32'(uop_op),         32'(mb.op));
                        chk("beat_ew",    32'(uop_elem_width), 32'(mb.ew));
                    end
                    last_hs = cyc;
                    beats_seen++;
                end else begin
                    prev_stall = 1;
                    p_row   = uop_row;
                    p_col   = uop_col;
                    p_bytes = uop_bytes;
                    p_last  = uop_last;
                end
            end
            if (mat_alu_cbus_ex1_pipe8_sel) begin
                if (cq.size() == 0) begin
                    chk("commit_unexpected", 32'd1, 32'd0);
                end else begin
                    mc = cq.pop_front();
                    chk("commit_iid",   32'(mat_alu_cbus_ex1_pipe8_iid), 32'(mc.iid));
                    chk("commit_cycle", 32'(cyc), 32'((mc.n == 0 ? mc.acc : last_hs) + 1));
                    if (mc.exp_cyc >= 0) chk("commit_latency", 32'(cyc), 32'(mc.exp_cyc));
                    chk("beats_left", 32'(bq.size()), 32'd0);
                    chk_idle = 1;
                end
            end
        end
    end

    // Tile-walk model: rows outer, byte offsets inner, final pushed beat is the last.
    task automatic issue(input logic [6:0] iid, input logic [10:0] op, input logic [1:0] ew,
                         input int k, input int m);
        beat_t b;
        cmt_t  c;
        int    n = 0;
        for (int r = 0; r < m; r++) begin
            for (int cc = 0; cc < k; cc += DP) begin
                b.row   = 8'(r);
                b.col   = 16'(cc);
                b.bytes = (k - cc < DP) ? (k - cc) : DP;
                b.last  = 0;
                b.op    = op;
                b.ew    = ew;
                bq.push_back(b);
                n++;
            end
        end
        if (n > 0) begin
            b = bq.pop_back();
            b.last = 1;
            bq.push_back(b);
        end
        c.iid = iid;
        c.n = n;
        c.acc = cyc;
        c.exp_cyc = (rdy_mode == 0) ? cyc + n + 1 : -1;
        cq.push_back(c);
        ex1_inst_vld   = 1'b1;
        ex1_iid        = iid;
        ex1_mat_op     = op;
        ex1_elem_width = ew;
        x_sizeK        = 16'(k);
        x_sizeM        = 8'(m);
        @(posedge forever_cpuclk); #1;
        ex1_inst_vld   = 1'b0;
        ex1_iid        = 7'($urandom);
        ex1_mat_op     = 11'($urandom);
        ex1_elem_width = 2'($urandom);
        x_sizeK        = 16'($urandom);
        x_sizeM        = 8'($urandom);
    endtask

    task automatic wait_drain(input int lim);
        int k = 0;
        while ((bq.size() != 0 || cq.size() != 0) && k < lim) begin
            @(posedge forever_cpuclk); #1;
            k++;
        end
        if (bq.size() != 0 || cq.size() != 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL drain_timeout: %0d beats and %0d commits still pending", bq.size(), cq.size());
            bq.delete();
            cq.delete();
        end
        @(posedge forever_cpuclk); #1;
    endtask

    task automatic wait_beats(input int target);
        int k = 0;
        while (beats_seen < target && k < 200) begin
            @(posedge forever_cpuclk); #1;
            k++;
        end
        chk("beats_reached", 32'(beats_seen >= target), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_idle"},  32'(seq_idle),  32'd1);
        chk({tag, "_vld"},   32'(uop_vld),   32'd0);
        chk({tag, "_row"},   32'(uop_row),   32'd0);
        chk({tag, "_col"},   32'(uop_col),   32'd0);
        chk({tag, "_bytes"}, 32'(uop_bytes), 32'd0);
        chk({tag, "_last"},  32'(uop_last),  32'd0);
        chk({tag, "_op"},    32'(uop_op),    32'd0);
        chk({tag, "_ew"},    32'(uop_elem_width), 32'd0);
        chk({tag, "_sel"},   32'(mat_alu_cbus_ex1_pipe8_sel), 32'd0);
        chk({tag, "_iid"},   32'(mat_alu_cbus_ex1_pipe8_iid), 32'd0);
    endtask

    task automatic run(input logic [6:0] iid, input int k, input int m, input int lim);
        issue(iid, 11'(1) << $urandom_range(0, 10), 2'($urandom), k, m);
        wait_drain(lim);
    endtask

    initial begin
        int bs;
        cpurst_b        = 1'b0;
        rtu_yy_xx_flush = 1'b0;
        ex1_inst_vld    = 1'b0;
        ex1_iid         = 7'd0;
        ex1_mat_op      = 11'd0;
        ex1_elem_width  = 2'd0;
        x_sizeK         = 16'd0;
        x_sizeM         = 8'd0;
        uop_rdy         = 1'b0;
        repeat (3) @(posedge forever_cpuclk);
        @(negedge forever_cpuclk);
        check_reset_outputs("in_reset");
        @(posedge forever_cpuclk); #1;
        cpurst_b = 1'b1;
        @(negedge forever_cpuclk);
        check_reset_outputs("post_reset");
        @(posedge forever_cpuclk); #1;

        // Basic tile, then the same tile with stalling ready.
        rdy_mode = 0;
        run(7'h15, 40, 2, 100);
        rdy_mode = 1;
        run(7'h15, 40, 2, 100);
        rdy_mode = 0;

        // Zero-size tiles commit without beats.
        run(7'h03, 40, 0, 20);
        run(7'h03, 0, 2, 20);

        // Flush during the third beat.
        bs = beats_seen;
        issue(7'h15, 11'h004, 2'd1, 40, 2);
        wait_beats(bs + 2);
        rtu_yy_xx_flush = 1'b1;
        bq.delete();
        cq.delete();
        @(negedge forever_cpuclk);
        chk("flush_vld", 32'(uop_vld), 32'd0);
        chk("flush_sel", 32'(mat_alu_cbus_ex1_pipe8_sel), 32'd0);
        @(posedge forever_cpuclk); #1;
        rtu_yy_xx_flush = 1'b0;
        @(negedge forever_cpuclk);
        chk("flush_idle", 32'(seq_idle), 32'd1);
        chk("flush_novld", 32'(uop_vld), 32'd0);
        @(posedge forever_cpuclk); #1;
        run(7'h2a, 16, 1, 20);

        // An instruction presented with flush is dropped.
        rtu_yy_xx_flush = 1'b1;
        ex1_inst_vld    = 1'b1;
        x_sizeK         = 16'd32;
        x_sizeM         = 8'd1;
        @(posedge forever_cpuclk); #1;
        rtu_yy_xx_flush = 1'b0;
        ex1_inst_vld    = 1'b0;
        @(negedge forever_cpuclk);
        chk("flush_drop_idle", 32'(seq_idle), 32'd1);
        chk("flush_drop_vld",  32'(uop_vld),  32'd0);
        repeat (4) @(posedge forever_cpuclk);
        #1;

        // Reset mid-RUN aborts without a commit.
        bs = beats_seen;
        issue(7'h11, 11'h100, 2'd2, 40, 2);
        wait_beats(bs + 3);
        cpurst_b = 1'b0;
        bq.delete();
        cq.delete();
        @(posedge forever_cpuclk); #1;
        cpurst_b = 1'b1;
        @(negedge forever_cpuclk);
        check_reset_outputs("mid_reset");
        repeat (4) @(posedge forever_cpuclk);
        #1;

        // Boundary sizes.
        run(7'h7f, 16'hFFFF, 1, 5000);
        run(7'h01, 16, 255, 400);

        // Randomized tiles and ready patterns.
        for (int i = 0; i < 25; i++) begin
            rdy_mode = $urandom_range(0, 2);
            run(7'($urandom), ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 70),
                $urandom_range(0, 3), 1000);
            if ($urandom_range(0, 1) == 1) begin
                @(posedge forever_cpuclk); #1;
            end
        end
        rdy_mode = 0;
        repeat (3) @(posedge forever_cpuclk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
